// File: rtl/gtv_pulse_gen.sv
// Replays an 8-bit count as a burst of evenly spaced output pulses.
// Single-clock FSM with an edge-detected start request and a cancelling abort.
module gtv_pulse_gen #(
   parameter int CNT_W    = 8,
   parameter int TICK_DIV = 250000,
   parameter int PULSE_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] count_in,
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   localparam int            BW        = $clog2(TICK_DIV);
   localparam logic [BW-1:0] BASE_LAST = BW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BASE_HIGH = BW'(PULSE_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic            start_ff;
   logic [BW-1:0]   base;
   logic            start_edge;

   assign start_edge = start & ~start_ff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         start_ff  <= 1'b0;
         base      <= '0;
         remaining <= '0;
      end else begin
         start_ff <= start;
         case (state)
            IDLE: begin
               if (!abort && start_edge) begin
                  if (count_in != '0) begin
                     remaining <= count_in;
                     base      <= '0;
                     state     <= RUN;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               // abort outranks the terminal decrement so a cancelled burst never strobes done
               if (abort) begin
                  remaining <= '0;
                  base      <= '0;
                  state     <= IDLE;
               end else if (base == BASE_LAST) begin
                  base      <= '0;
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1))
                     state <= DONE;
               end else begin
                  base <= base + BW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from registers, so reset clears them without waiting for a clock.
   assign pulse = (state == RUN) && (base < BASE_HIGH);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

endmodule
